// File: rtl/load_align_extend_unit.sv
// load_align_extend_unit
// MEM/WB load formatter. It picks the addressed byte, half, word or dword out of an
// aligned memory word and sign- or zero-extends it to XLEN. A load that runs past the
// end of the word either fetches the next aligned word and merges the two beats, or is
// reported as an error, depending on ALLOW_MISALIGN. Results sit in an output register
// behind a valid/ready handshake, so one load per cycle flows through when nothing stalls.

module load_align_extend_unit #(
    parameter int XLEN           = 32,
    parameter int TAG_W          = 5,
    parameter int ALLOW_MISALIGN = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [XLEN-1:0]             in_data,
    input  logic [$clog2(XLEN/8)-1:0]   in_offset,
    input  logic [1:0]                  in_size,
    input  logic                        in_signed,
    input  logic [TAG_W-1:0]            in_tag,
    output logic                        hi_req,
    input  logic                        hi_valid,
    input  logic [XLEN-1:0]             hi_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             out_data,
    output logic [TAG_W-1:0]            out_tag,
    output logic                        out_err
);

    localparam int OFF_W = $clog2(XLEN/8);
    // Wide enough to hold offset + byte count without overflow (max 7 + 8 = 15).
    localparam int SUM_W = OFF_W + 2;

    typedef enum logic {
        IDLE,
        WAIT_HI
    } state_t;

    state_t              r_state;
    logic [XLEN-1:0]     r_loData;
    logic [OFF_W-1:0]    r_loOffset;
    logic [1:0]          r_loSize;
    logic                r_loSigned;
    logic [TAG_W-1:0]    r_loTag;
    logic                r_hiReq;
    logic                r_outValid;
    logic                r_outErr;
    logic [XLEN-1:0]     r_outData;
    logic [TAG_W-1:0]    r_outTag;

    logic [SUM_W-1:0]    w_nbytes;
    logic                w_cross;
    logic                w_illegal;
    logic                w_misalignErr;
    logic                w_inReady;
    logic                w_accept;
    logic [XLEN-1:0]     w_directResult;
    logic [XLEN-1:0]     w_splitResult;

    // Shift the addressed bytes down to bit 0 of a two-word window, then fill every bit
    // above the loaded size with either zeros or the loaded value's top bit. The fill is
    // done with a mask so the same code serves XLEN=32 and XLEN=64 (a dword mask is empty,
    // which makes the extension a no-op).
    function automatic logic [XLEN-1:0] extendLoad(
        input logic [2*XLEN-1:0] window,
        input logic [OFF_W-1:0]  offset,
        input logic [1:0]        size,
        input logic              isSigned
    );
        logic [XLEN-1:0] shifted;
        logic [XLEN-1:0] mask;
        logic            signBit;
        shifted = XLEN'(window >> {offset, 3'b000});
        case (size)
            2'b00: begin
                signBit = shifted[7];
                mask    = {XLEN{1'b1}} << 8;
            end
            2'b01: begin
                signBit = shifted[15];
                mask    = {XLEN{1'b1}} << 16;
            end
            2'b10: begin
                signBit = shifted[31];
                mask    = (XLEN > 32) ? ({XLEN{1'b1}} << 32) : '0;
            end
            default: begin
                signBit = shifted[XLEN-1];
                mask    = '0;
            end
        endcase
        return (shifted & ~mask) | ((isSigned && signBit) ? mask : '0);
    endfunction

    // Classify the incoming request: byte count, word crossing, illegal size.
    always_comb begin
        w_nbytes      = SUM_W'(1) << in_size;
        w_cross       = ({2'b00, in_offset} + w_nbytes) > SUM_W'(XLEN/8);
        w_illegal     = (in_size == 2'b11) && (XLEN == 32);
        w_misalignErr = w_cross && (ALLOW_MISALIGN == 0);
        w_inReady     = (r_state == IDLE) && (!r_outValid || out_ready);
        w_accept      = in_valid && w_inReady;
    end

    // Formatted results for the single-beat path and for a completed split.
    always_comb begin
        w_directResult = extendLoad({{XLEN{1'b0}}, in_data}, in_offset, in_size, in_signed);
        w_splitResult  = extendLoad({hi_data, r_loData}, r_loOffset, r_loSize, r_loSigned);
    end

    // Control FSM plus output register. The output register empties on drain unless a
    // new result overwrites it at the same edge, which is what gives back-to-back loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_loData   <= '0;
            r_loOffset <= '0;
            r_loSize   <= '0;
            r_loSigned <= 1'b0;
            r_loTag    <= '0;
            r_hiReq    <= 1'b0;
            r_outValid <= 1'b0;
            r_outErr   <= 1'b0;
            r_outData  <= '0;
            r_outTag   <= '0;
        end else begin
            if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_illegal || w_misalignErr) begin
                            r_outValid <= 1'b1;
                            r_outErr   <= 1'b1;
                            r_outData  <= '0;
                            r_outTag   <= in_tag;
                        end else if (w_cross) begin
                            r_loData   <= in_data;
                            r_loOffset <= in_offset;
                            r_loSize   <= in_size;
                            r_loSigned <= in_signed;
                            r_loTag    <= in_tag;
                            r_hiReq    <= 1'b1;
                            r_state    <= WAIT_HI;
                        end else begin
                            r_outValid <= 1'b1;
                            r_outErr   <= 1'b0;
                            r_outData  <= w_directResult;
                            r_outTag   <= in_tag;
                        end
                    end
                end
                WAIT_HI: begin
                    if (hi_valid) begin
                        r_outValid <= 1'b1;
                        r_outErr   <= 1'b0;
                        r_outData  <= w_splitResult;
                        r_outTag   <= r_loTag;
                        r_hiReq    <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_hiReq <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_inReady;
    assign hi_req    = r_hiReq;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_tag   = r_outTag;
    assign out_err   = r_outErr;

endmodule

// File: tb/tb_load_align_extend_unit.sv
// Testbench for load_align_extend_unit.
// Instance A is XLEN=32 with misaligned splitting enabled; instance B is XLEN=64 with
// misaligned loads reported as errors. Directed vectors with hand-computed results.

module tb_load_align_extend_unit;

    logic clk;
    logic rst_n;

    logic        aInValid, aInReady, aInSigned, aHiReq, aHiValid, aOutValid, aOutReady, aOutErr;
    logic [31:0] aInData, aHiData, aOutData;
    logic [1:0]  aInOffset, aInSize;
    logic [4:0]  aInTag, aOutTag;

    logic        bInValid, bInReady, bInSigned, bHiReq, bHiValid, bOutValid, bOutReady, bOutErr;
    logic [63:0] bInData, bHiData, bOutData;
    logic [2:0]  bInOffset;
    logic [1:0]  bInSize;
    logic [4:0]  bInTag, bOutTag;

    int checkCount;
    int passCount;

    load_align_extend_unit #(.XLEN(32), .TAG_W(5), .ALLOW_MISALIGN(1)) dutA (
        .clk(clk), .rst_n(rst_n),
        .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData), .in_offset(aInOffset),
        .in_size(aInSize), .in_signed(aInSigned), .in_tag(aInTag),
        .hi_req(aHiReq), .hi_valid(aHiValid), .hi_data(aHiData),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
        .out_tag(aOutTag), .out_err(aOutErr)
    );

    load_align_extend_unit #(.XLEN(64), .TAG_W(5), .ALLOW_MISALIGN(0)) dutB (
        .clk(clk), .rst_n(rst_n),
        .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData), .in_offset(bInOffset),
        .in_size(bInSize), .in_signed(bInSigned), .in_tag(bInTag),
        .hi_req(bHiReq), .hi_valid(bHiValid), .hi_data(bHiData),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
        .out_tag(bOutTag), .out_err(bOutErr)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and tally the outcome.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge, where registered outputs are settled.
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // Present one request to instance A for a single cycle.
    task automatic applyStimulus(input logic [31:0] data, input logic [1:0] off,
                                 input logic [1:0] size, input logic sgn, input logic [4:0] tag);
        aInData   = data;
        aInOffset = off;
        aInSize   = size;
        aInSigned = sgn;
        aInTag    = tag;
        aInValid  = 1'b1;
        stepClk();
        aInValid  = 1'b0;
    endtask

    // Present one request to instance B for a single cycle.
    task automatic applyStimulusB(input logic [63:0] data, input logic [2:0] off,
                                  input logic [1:0] size, input logic sgn, input logic [4:0] tag);
        bInData   = data;
        bInOffset = off;
        bInSize   = size;
        bInSigned = sgn;
        bInTag    = tag;
        bInValid  = 1'b1;
        stepClk();
        bInValid  = 1'b0;
    endtask

    logic [31:0] byteExp [4];

    initial begin
        checkCount = 0;
        passCount  = 0;
        byteExp[0] = 32'h11;
        byteExp[1] = 32'h22;
        byteExp[2] = 32'h33;
        byteExp[3] = 32'h44;

        rst_n     = 1'b0;
        aInValid  = 1'b0; aInData = '0; aInOffset = '0; aInSize = '0; aInSigned = 1'b0; aInTag = '0;
        aHiValid  = 1'b0; aHiData = '0; aOutReady = 1'b1;
        bInValid  = 1'b0; bInData = '0; bInOffset = '0; bInSize = '0; bInSigned = 1'b0; bInTag = '0;
        bHiValid  = 1'b0; bHiData = '0; bOutReady = 1'b1;

        // Reset state.
        stepClk();
        stepClk();
        checkOutput("rst out_valid", 64'(aOutValid), 64'd0);
        checkOutput("rst hi_req", 64'(aHiReq), 64'd0);
        checkOutput("rst out_data", 64'(aOutData), 64'd0);
        checkOutput("rst out_tag", 64'(aOutTag), 64'd0);
        checkOutput("rst in_ready", 64'(aInReady), 64'd1);
        rst_n = 1'b1;

        // Aligned byte, signed and unsigned.
        applyStimulus(32'h8899AABB, 2'd0, 2'b00, 1'b1, 5'd3);
        checkOutput("byte s valid", 64'(aOutValid), 64'd1);
        checkOutput("byte s data", 64'(aOutData), 64'hFFFFFFBB);
        checkOutput("byte s tag", 64'(aOutTag), 64'd3);
        checkOutput("byte s err", 64'(aOutErr), 64'd0);
        applyStimulus(32'h8899AABB, 2'd0, 2'b00, 1'b0, 5'd4);
        checkOutput("byte u data", 64'(aOutData), 64'h000000BB);

        // Half at offset 2, signed and unsigned; tag passthrough.
        applyStimulus(32'h8899AABB, 2'd2, 2'b01, 1'b1, 5'd7);
        checkOutput("half s data", 64'(aOutData), 64'hFFFF8899);
        checkOutput("half s tag", 64'(aOutTag), 64'd7);
        applyStimulus(32'h8899AABB, 2'd2, 2'b01, 1'b0, 5'd8);
        checkOutput("half u data", 64'(aOutData), 64'h00008899);
        applyStimulus(32'h8899AABB, 2'd3, 2'b00, 1'b1, 5'd2);
        checkOutput("byte3 s data", 64'(aOutData), 64'hFFFFFF88);

        // Word at offset 3 splits; hi word arrives after 3 idle cycles.
        applyStimulus(32'h44332211, 2'd3, 2'b10, 1'b0, 5'd9);
        checkOutput("split hi_req", 64'(aHiReq), 64'd1);
        checkOutput("split in_ready", 64'(aInReady), 64'd0);
        checkOutput("split drained", 64'(aOutValid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            stepClk();
            checkOutput("split hi_req held", 64'(aHiReq), 64'd1);
        end
        aHiData  = 32'h88776655;
        aHiValid = 1'b1;
        stepClk();
        aHiValid = 1'b0;
        checkOutput("split valid", 64'(aOutValid), 64'd1);
        checkOutput("split data", 64'(aOutData), 64'h77665544);
        checkOutput("split tag", 64'(aOutTag), 64'd9);
        checkOutput("split hi_req drop", 64'(aHiReq), 64'd0);
        checkOutput("split in_ready", 64'(aInReady), 64'd1);

        // Signed half split with hi word available in the first waiting cycle.
        applyStimulus(32'h11223344, 2'd3, 2'b01, 1'b1, 5'd12);
        aHiData  = 32'h000000AA;
        aHiValid = 1'b1;
        stepClk();
        aHiValid = 1'b0;
        checkOutput("split half data", 64'(aOutData), 64'hFFFFAA11);

        // Output hold under backpressure.
        applyStimulus(32'h000000CC, 2'd0, 2'b00, 1'b0, 5'd1);
        aOutReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stepClk();
            checkOutput("hold data", 64'(aOutData), 64'h000000CC);
            checkOutput("hold valid", 64'(aOutValid), 64'd1);
            checkOutput("hold in_ready", 64'(aInReady), 64'd0);
        end
        aOutReady = 1'b1;

        // Back-to-back aligned bytes, one result per cycle.
        aInData   = 32'h44332211;
        aInSize   = 2'b00;
        aInSigned = 1'b0;
        for (int i = 0; i < 4; i++) begin
            aInOffset = 2'(i);
            aInTag    = 5'(10 + i);
            aInValid  = 1'b1;
            stepClk();
            checkOutput("b2b data", 64'(aOutData), 64'(byteExp[i]));
            checkOutput("b2b tag", 64'(aOutTag), 64'(10 + i));
            checkOutput("b2b valid", 64'(aOutValid), 64'd1);
        end
        aInValid = 1'b0;
        stepClk();
        checkOutput("drain clears valid", 64'(aOutValid), 64'd0);

        // Illegal dword on XLEN=32, then error clears on a normal load.
        applyStimulus(32'h12345678, 2'd0, 2'b11, 1'b0, 5'd5);
        checkOutput("illegal err", 64'(aOutErr), 64'd1);
        checkOutput("illegal data", 64'(aOutData), 64'd0);
        checkOutput("illegal tag", 64'(aOutTag), 64'd5);
        checkOutput("illegal no hi_req", 64'(aHiReq), 64'd0);
        applyStimulus(32'h12345678, 2'd0, 2'b10, 1'b0, 5'd6);
        checkOutput("err clears", 64'(aOutErr), 64'd0);
        checkOutput("word data", 64'(aOutData), 64'h12345678);

        // XLEN=64 with misaligned loads flagged.
        applyStimulusB(64'h0011223344556677, 3'd7, 2'b01, 1'b0, 5'd2);
        checkOutput("B misalign err", 64'(bOutErr), 64'd1);
        checkOutput("B misalign data", bOutData, 64'd0);
        checkOutput("B misalign hi_req", 64'(bHiReq), 64'd0);
        checkOutput("B misalign tag", 64'(bOutTag), 64'd2);
        applyStimulusB(64'h8123456789ABCDEF, 3'd0, 2'b11, 1'b1, 5'd3);
        checkOutput("B dword err", 64'(bOutErr), 64'd0);
        checkOutput("B dword data", bOutData, 64'h8123456789ABCDEF);
        applyStimulusB(64'h8000000000000000, 3'd4, 2'b10, 1'b1, 5'd4);
        checkOutput("B word s data", bOutData, 64'hFFFFFFFF80000000);
        applyStimulusB(64'h8000000000000000, 3'd4, 2'b10, 1'b0, 5'd4);
        checkOutput("B word u data", bOutData, 64'h0000000080000000);
        applyStimulusB(64'h000000ABCD000000, 3'd3, 2'b01, 1'b1, 5'd5);
        checkOutput("B half s data", bOutData, 64'hFFFFFFFFFFFFABCD);
        applyStimulusB(64'h0011223344556677, 3'd5, 2'b10, 1'b0, 5'd6);
        checkOutput("B word cross err", 64'(bOutErr), 64'd1);
        checkOutput("B word cross data", bOutData, 64'd0);

        // Reset during a pending split aborts it.
        applyStimulus(32'h44332211, 2'd1, 2'b10, 1'b0, 5'd4);
        checkOutput("abort hi_req set", 64'(aHiReq), 64'd1);
        rst_n = 1'b0;
        stepClk();
        checkOutput("abort hi_req", 64'(aHiReq), 64'd0);
        checkOutput("abort out_valid", 64'(aOutValid), 64'd0);
        checkOutput("abort in_ready", 64'(aInReady), 64'd1);
        rst_n    = 1'b1;
        aHiData  = 32'hDEADBEEF;
        aHiValid = 1'b1;
        stepClk();
        aHiValid = 1'b0;
        checkOutput("abort stray hi", 64'(aOutValid), 64'd0);
        stepClk();
        checkOutput("abort stray hi later", 64'(aOutValid), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
